// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default divisors for the stopwatch sequencer.
// STOPWATCH_CTRL_BLINK_EN adds the blink divisor default.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE  = 2'd0,
        ST_RUN    = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    localparam int RUN_DIV_DEF = 100_000_000;
    localparam int ADJ_DIV_DEF = 50_000_000;
`ifdef STOPWATCH_CTRL_BLINK_EN
    localparam int BLINK_DIV_DEF = 25_000_000;
`endif

endpackage

// File: rtl/tick_gen.sv
// Modulo-DIV counter emitting a one-cycle tick at DIV-1.
// en=0 holds the count; clr has priority over en.
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    assign tick = en & (cnt == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// RUN/PAUSE/ADJUST sequencer producing count strobes for the seconds/minutes counters.
// STOPWATCH_CTRL_BLINK_EN enables the blink gate divider used while adjusting.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int RUN_DIV = RUN_DIV_DEF,
    parameter int ADJ_DIV = ADJ_DIV_DEF
`ifdef STOPWATCH_CTRL_BLINK_EN
    ,
    parameter int BLINK_DIV = BLINK_DIV_DEF
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_btn,
    input  logic       clr_btn,
    input  logic       adj,
    input  logic       sel,
    input  logic       sec_at_max,
    output logic       sec_en,
    output logic       min_en,
    output logic       cnt_clr,
    output logic       running,
    output logic       blink,
    output logic [1:0] fsm_state
);
    state_t state;
    logic   saved_run;
    logic   pause_q, clr_q, pause_rise, clr_rise;
    logic   in_run, in_adj, enter_adj, exit_adj;
    logic   run_tick, adj_tick;

    assign in_run    = (state == ST_RUN);
    assign in_adj    = (state == ST_ADJUST);
    assign enter_adj = !in_adj && adj;
    assign exit_adj  = in_adj && !adj;
    assign fsm_state = state;

    // Rise is registered so it acts one edge after it is seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pause_q    <= 1'b0;
            clr_q      <= 1'b0;
            pause_rise <= 1'b0;
            clr_rise   <= 1'b0;
        end else begin
            pause_q    <= pause_btn;
            clr_q      <= clr_btn;
            pause_rise <= pause_btn & ~pause_q;
            clr_rise   <= clr_btn & ~clr_q;
        end
    end

    tick_gen #(.DIV(RUN_DIV)) u_run_div (
        .clk  (clk),
        .rst  (rst),
        .en   (in_run),
        .clr  (clr_rise),
        .tick (run_tick)
    );

    tick_gen #(.DIV(ADJ_DIV)) u_adj_div (
        .clk  (clk),
        .rst  (rst),
        .en   (in_adj),
        .clr  (clr_rise | enter_adj),
        .tick (adj_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_PAUSE;
            saved_run <= 1'b0;
            running   <= 1'b0;
            sec_en    <= 1'b0;
            min_en    <= 1'b0;
            cnt_clr   <= 1'b0;
        end else begin
            // A pause rise coincident with entry is folded into saved_run; at exit it is lost.
            if (enter_adj) begin
                state     <= ST_ADJUST;
                saved_run <= in_run ^ pause_rise;
                running   <= 1'b0;
            end else if (exit_adj) begin
                state   <= saved_run ? ST_RUN : ST_PAUSE;
                running <= saved_run;
            end else if (pause_rise) begin
                case (state)
                    ST_PAUSE: begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                    ST_RUN: begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end
                    default: saved_run <= ~saved_run;
                endcase
            end

            cnt_clr <= clr_rise;
            if (clr_rise) begin
                sec_en <= 1'b0;
                min_en <= 1'b0;
            end else if (run_tick) begin
                sec_en <= 1'b1;
                min_en <= sec_at_max;
            end else if (adj_tick) begin
                sec_en <= ~sel;
                min_en <= sel;
            end else begin
                sec_en <= 1'b0;
                min_en <= 1'b0;
            end
        end
    end

`ifdef STOPWATCH_CTRL_BLINK_EN
    logic blink_tick;

    tick_gen #(.DIV(BLINK_DIV)) u_blink_div (
        .clk  (clk),
        .rst  (rst),
        .en   (in_adj),
        .clr  (enter_adj | exit_adj),
        .tick (blink_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink <= 1'b0;
        end else if (enter_adj || exit_adj) begin
            blink <= 1'b0;
        end else if (blink_tick) begin
            blink <= ~blink;
        end
    end
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: cycle model compared every negedge plus directed literal checks.
// Honours STOPWATCH_CTRL_BLINK_EN for the blink output.
module tb_stopwatch_ctrl;
    localparam int RUN_DIV   = 10;
    localparam int ADJ_DIV   = 5;
    localparam int BLINK_DIV = 3;
    localparam int MD_PAUSE  = 0;
    localparam int MD_RUN    = 1;
    localparam int MD_ADJ    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       pause_btn, clr_btn, adj, sel, sec_at_max;
    logic       sec_en, min_en, cnt_clr, running, blink;
    logic [1:0] fsm_state;

    int vectors     = 0;
    int miscompares = 0;

    stopwatch_ctrl #(
        .RUN_DIV   (RUN_DIV),
        .ADJ_DIV   (ADJ_DIV)
`ifdef STOPWATCH_CTRL_BLINK_EN
        ,
        .BLINK_DIV (BLINK_DIV)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pause_btn  (pause_btn),
        .clr_btn    (clr_btn),
        .adj        (adj),
        .sel        (sel),
        .sec_at_max (sec_at_max),
        .sec_en     (sec_en),
        .min_en     (min_en),
        .cnt_clr    (cnt_clr),
        .running    (running),
        .blink      (blink),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: elapsed-cycle counts per mode, ticks by modular arithmetic.
    int m_mode = MD_PAUSE;
    bit m_saved = 0;
    int run_el = 0, adj_el = 0, blk_el = 0;
    bit p_last = 0, c_last = 0, p_pend = 0, c_pend = 0;
    bit e_sec = 0, e_min = 0, e_clr = 0, e_run = 0, e_blink = 0;
    bit act_p, act_c, t_run, t_adj, t_blk;
    int nxt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = MD_PAUSE; m_saved = 0;
            run_el = 0; adj_el = 0; blk_el = 0;
            p_last = 0; c_last = 0; p_pend = 0; c_pend = 0;
            e_sec = 0; e_min = 0; e_clr = 0; e_run = 0; e_blink = 0;
        end else begin
            act_p = p_pend;
            act_c = c_pend;
            t_run = (m_mode == MD_RUN) && ((run_el % RUN_DIV) == RUN_DIV - 1);
            t_adj = (m_mode == MD_ADJ) && ((adj_el % ADJ_DIV) == ADJ_DIV - 1);
            t_blk = (m_mode == MD_ADJ) && ((blk_el % BLINK_DIV) == BLINK_DIV - 1);
            e_clr = act_c;
            e_sec = !act_c && (t_run || (t_adj && !sel));
            e_min = !act_c && ((t_run && sec_at_max) || (t_adj && sel));
            if (act_c) begin
                run_el = 0;
                adj_el = 0;
            end else begin
                if (m_mode == MD_RUN) run_el++;
                if (m_mode == MD_ADJ) adj_el++;
            end
            if (m_mode == MD_ADJ) blk_el++;
`ifdef STOPWATCH_CTRL_BLINK_EN
            if (t_blk) e_blink = !e_blink;
`endif
            nxt = m_mode;
            if (m_mode != MD_ADJ && adj) begin
                m_saved = (m_mode == MD_RUN) ^ act_p;
                nxt = MD_ADJ;
                adj_el = 0; blk_el = 0; e_blink = 0;
            end else if (m_mode == MD_ADJ && !adj) begin
                nxt = m_saved ? MD_RUN : MD_PAUSE;
                blk_el = 0; e_blink = 0;
            end else if (act_p) begin
                if (m_mode == MD_ADJ) m_saved = !m_saved;
                else nxt = (m_mode == MD_RUN) ? MD_PAUSE : MD_RUN;
            end
            m_mode = nxt;
            e_run  = (m_mode == MD_RUN);
            p_pend = pause_btn && !p_last;
            p_last = pause_btn;
            c_pend = clr_btn && !c_last;
            c_last = clr_btn;
        end
    end

    always @(negedge clk) begin
        chk("m_sec_en",  sec_en,    e_sec);
        chk("m_min_en",  min_en,    e_min);
        chk("m_cnt_clr", cnt_clr,   e_clr);
        chk("m_running", running,   e_run);
        chk("m_blink",   blink,     e_blink);
        chk("m_state",   fsm_state, m_mode);
    end

    task automatic press_pause();
        pause_btn = 1'b1;
        @(negedge clk);
        pause_btn = 1'b0;
    endtask

    task automatic count_window(input int n, output int s, output int m, output int c, output int both);
        s = 0; m = 0; c = 0; both = 0;
        repeat (n) begin
            @(negedge clk);
            s    += int'(sec_en);
            m    += int'(min_en);
            c    += int'(cnt_clr);
            both += int'(sec_en & min_en);
        end
    endtask

    task automatic wait_sec(input int budget, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!sec_en && waited < budget);
        if (!sec_en) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_sec: no sec_en within %0d cycles", budget);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, m, c, b, w;
        rst = 1'b0; pause_btn = 1'b0; clr_btn = 1'b0;
        adj = 1'b0; sel = 1'b0; sec_at_max = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sec_en", sec_en, 0);
        chk("rst_running", running, 0);
        chk("rst_state", fsm_state, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: start, sec_en every 10 clk
        press_pause();
        @(negedge clk);
        chk("t1_running", running, 1);
        count_window(38, s, m, c, b);
        chk("t1_sec_count", s, 3);
        chk("t1_min_count", m, 0);
        wait_sec(20, w);
        chk("t1_next_sec", w, 2);
        wait_sec(20, w);
        chk("t1_sec_period", w, 10);

        // 2: carry into minutes
        sec_at_max = 1'b1;
        count_window(10, s, m, c, b);
        sec_at_max = 1'b0;
        chk("t2_sec", s, 1);
        chk("t2_min", m, 1);
        chk("t2_coincident", b, 1);
        count_window(25, s, m, c, b);
        chk("t2_sec_after", s, 2);
        chk("t2_min_after", m, 0);

        // 3: pause with divider at 4, resume after 6 more counts
        wait_sec(20, w);
        chk("t3_sync", w, 5);
        repeat (2) @(negedge clk);
        press_pause();
        count_window(30, s, m, c, b);
        chk("t3_paused_sec", s, 0);
        chk("t3_paused_running", running, 0);
        press_pause();
        @(negedge clk);
        chk("t3_resumed", running, 1);
        wait_sec(20, w);
        chk("t3_first_sec", w, 6);

        // 4: adjust minutes from RUN, pause rise inside adjust, exit to PAUSE
        adj = 1'b1; sel = 1'b1;
        count_window(9, s, m, c, b);
        chk("t4_min_a", m, 1);
        chk("t4_sec_a", s, 0);
        press_pause();
        count_window(12, s, m, c, b);
        chk("t4_min_b", m, 3);
        chk("t4_sec_b", s, 0);
        adj = 1'b0;
        @(negedge clk);
        chk("t4_exit_running", running, 0);
        chk("t4_exit_state", fsm_state, 0);
        count_window(20, s, m, c, b);
        chk("t4_idle_strobes", s + m, 0);

        // 5: clear coincident with run tick
        press_pause();
        wait_sec(20, w);
        chk("t5_first_sec", w, 10);
        repeat (8) @(negedge clk);
        clr_btn = 1'b1;
        @(negedge clk);
        clr_btn = 1'b0;
        count_window(1, s, m, c, b);
        chk("t5_cnt_clr", c, 1);
        chk("t5_tick_dropped", s, 0);
        wait_sec(20, w);
        chk("t5_sec_after_clr", w, 10);

        // 6: adjust seconds then asynchronous reset
        adj = 1'b1; sel = 1'b0;
        count_window(12, s, m, c, b);
        chk("t6_adj_sec", s, 2);
        chk("t6_adj_min", m, 0);
        #3 rst = 1'b0;
        #1;
        chk("t6_rst_sec", sec_en, 0);
        chk("t6_rst_min", min_en, 0);
        chk("t6_rst_blink", blink, 0);
        chk("t6_rst_state", fsm_state, 0);
        @(negedge clk);
        rst = 1'b1; adj = 1'b0;
        count_window(15, s, m, c, b);
        chk("t6_post_rst", s + m + c, 0);
        chk("t6_post_running", running, 0);

        // 7: adj entry coincident with pause rise sets saved_run
        pause_btn = 1'b1;
        @(negedge clk);
        pause_btn = 1'b0; adj = 1'b1;
        @(negedge clk);
        chk("t7_state_adj", fsm_state, 2);
        repeat (5) @(negedge clk);
        adj = 1'b0;
        @(negedge clk);
        chk("t7_exit_run", running, 1);
        chk("t7_exit_state", fsm_state, 1);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
